// File: rtl/aemb_arb_pkg.sv
// Shared types for the AEMB Wishbone instruction/data arbiter.
package aemb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } arb_mst_e;

    // Tie resolution: fixed priority always favours dwb, round-robin
    // favours whichever master was not served last.
    function automatic logic tie_to_d(input logic rr, input arb_mst_e last);
        return !rr || (last == MST_I);
    endfunction

endpackage

// File: rtl/aemb_arb_tmo.sv
// Watchdog for the AEMB arbiter: flags the (2**TMO_W-1)-th unacked cycle.
module aemb_arb_tmo #(
    parameter int TMO_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Count holds the cycles already spent, so this cycle is the final one.
    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/aemb_wb_arb.sv
// AEMB iwb/dwb to shared Wishbone arbiter with hung-transfer watchdog.
// Define AEMB_ARB_RR_EN for round-robin tie breaking (default: dwb wins).
module aemb_wb_arb
    import aemb_arb_pkg::*;
#(
    parameter int AW    = 32,
    parameter int TMO_W = 8
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          iwb_stb_i,
    input  logic [AW-1:2] iwb_adr_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          mwb_cyc_o,
    output logic          mwb_stb_o,
    output logic          mwb_we_o,
    output logic [3:0]    mwb_sel_o,
    output logic [AW-1:2] mwb_adr_o,
    output logic [31:0]   mwb_dat_o,
    input  logic [31:0]   mwb_dat_i,
    input  logic          mwb_ack_i,
    output logic          tmo_o
);

`ifdef AEMB_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    arb_state_e r_state;
    arb_state_e w_next;
    arb_mst_e   r_last;
    logic       r_tmo;

    logic w_gnt_i;
    logic w_gnt_d;
    logic w_live;
    logic w_ack;
    logic w_expire;
    logic w_run;

    assign w_gnt_i = (r_state == GNT_I);
    assign w_gnt_d = (r_state == GNT_D);

    // A dropped strobe or a reset in flight kills the transfer outright.
    assign w_live = ((w_gnt_i & iwb_stb_i) | (w_gnt_d & dwb_stb_i))
                  & ~sys_rst_i;
    assign w_ack  = w_live & mwb_ack_i;
    assign w_run  = w_live & ~w_expire;

    aemb_arb_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .i_clk    (sys_clk_i),
        .i_rst    (sys_rst_i),
        .i_clr    (~w_live),
        .i_en     (w_live & ~mwb_ack_i),
        .o_expire (w_expire)
    );

    assign mwb_cyc_o = w_run;
    assign mwb_stb_o = w_run;
    assign mwb_we_o  = w_run & w_gnt_d & dwb_wre_i;
    assign mwb_sel_o = !w_run ? 4'h0 : (w_gnt_d ? dwb_sel_i : 4'hF);
    assign mwb_adr_o = !w_run ? '0 : (w_gnt_d ? dwb_adr_i : iwb_adr_i);
    assign mwb_dat_o = (w_run & w_gnt_d) ? dwb_dat_i : 32'h0;

    assign iwb_ack_o = w_gnt_i & (w_ack | w_expire);
    assign dwb_ack_o = w_gnt_d & (w_ack | w_expire);
    assign iwb_dat_o = (w_run & w_gnt_i) ? mwb_dat_i : 32'h0;
    assign dwb_dat_o = (w_run & w_gnt_d) ? mwb_dat_i : 32'h0;

    assign tmo_o = r_tmo & ~sys_rst_i;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (dwb_stb_i && iwb_stb_i) begin
                    w_next = tie_to_d(RR, r_last) ? GNT_D : GNT_I;
                end else if (dwb_stb_i) begin
                    w_next = GNT_D;
                end else if (iwb_stb_i) begin
                    w_next = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (!w_live || w_ack || w_expire) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= IDLE;
            r_last  <= MST_I;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ack) begin
                r_last <= w_gnt_d ? MST_D : MST_I;
            end
            if (w_expire) begin
                r_tmo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aemb_wb_arb.sv
// Self-checking bench for aemb_wb_arb with a transfer-level reference model.
module tb_aemb_wb_arb;

    localparam int AW    = 32;
    localparam int TMO_W = 3;
    localparam int LIM   = (1 << TMO_W) - 1;

`ifdef AEMB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sys_rst_i;
    logic          iwb_stb_i;
    logic [AW-1:2] iwb_adr_i;
    logic [31:0]   iwb_dat_o;
    logic          iwb_ack_o;
    logic          dwb_stb_i;
    logic          dwb_wre_i;
    logic [3:0]    dwb_sel_i;
    logic [AW-1:2] dwb_adr_i;
    logic [31:0]   dwb_dat_i;
    logic [31:0]   dwb_dat_o;
    logic          dwb_ack_o;
    logic          mwb_cyc_o;
    logic          mwb_stb_o;
    logic          mwb_we_o;
    logic [3:0]    mwb_sel_o;
    logic [AW-1:2] mwb_adr_o;
    logic [31:0]   mwb_dat_o;
    logic [31:0]   mwb_dat_i;
    logic          mwb_ack_i;
    logic          tmo_o;

    logic [135:0]  w_outs;

    int checks = 0;
    int errors = 0;
    bit m_last_d;
    bit m_tmo;

    always #5 clk = ~clk;

    assign w_outs = {iwb_dat_o, iwb_ack_o, dwb_dat_o, dwb_ack_o,
                     mwb_cyc_o, mwb_stb_o, mwb_we_o, mwb_sel_o,
                     mwb_adr_o, mwb_dat_o, tmo_o};

    aemb_wb_arb #(
        .AW    (AW),
        .TMO_W (TMO_W)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (sys_rst_i),
        .iwb_stb_i (iwb_stb_i),
        .iwb_adr_i (iwb_adr_i),
        .iwb_dat_o (iwb_dat_o),
        .iwb_ack_o (iwb_ack_o),
        .dwb_stb_i (dwb_stb_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_dat_o (dwb_dat_o),
        .dwb_ack_o (dwb_ack_o),
        .mwb_cyc_o (mwb_cyc_o),
        .mwb_stb_o (mwb_stb_o),
        .mwb_we_o  (mwb_we_o),
        .mwb_sel_o (mwb_sel_o),
        .mwb_adr_o (mwb_adr_o),
        .mwb_dat_o (mwb_dat_o),
        .mwb_dat_i (mwb_dat_i),
        .mwb_ack_i (mwb_ack_i),
        .tmo_o     (tmo_o)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        iwb_stb_i = 1'b0;
        iwb_adr_i = '0;
        dwb_stb_i = 1'b0;
        dwb_wre_i = 1'b0;
        dwb_sel_i = 4'h0;
        dwb_adr_i = '0;
        dwb_dat_i = 32'h0;
        mwb_dat_i = 32'h0;
        mwb_ack_i = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        sys_rst_i = 1'b1;
        tick();
        tick();
        sys_rst_i = 1'b0;
        m_last_d = 1'b0;
        m_tmo = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst_i = 1'b1;
        iwb_stb_i = 1'b1;
        dwb_stb_i = 1'b1;
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'hFFFF_FFFF;
        repeat (3) begin
            tick();
            #1;
            checks++;
            if (w_outs !== '0) begin
                errors++;
                $display("FAIL reset_outs: got %h want 0", w_outs);
            end
        end
        idle_inputs();
        sys_rst_i = 1'b0;
        m_last_d = 1'b0;
        m_tmo = 1'b0;
        tick();
        #1;
        checks++;
        if (w_outs !== '0) begin
            errors++;
            $display("FAIL idle_outs: got %h want 0", w_outs);
        end
    endtask

    task automatic test_iwb_single;
        tick();
        iwb_stb_i = 1'b1;
        iwb_adr_i = 30'h10;
        #1;
        checks++;
        if (mwb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency: stb %b want 0", mwb_stb_o);
        end
        tick();
        #1;
        checks++;
        if ({mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o, iwb_ack_o}
            !== {1'b1, 1'b0, 4'hF, 30'h10, 1'b0}) begin
            errors++;
            $display("FAIL t1_grant: stb %b we %b sel %h adr %h ack %b",
                     mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o, iwb_ack_o);
        end
        tick();
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'hB000_0000;
        #1;
        checks++;
        if ({iwb_ack_o, iwb_dat_o, dwb_ack_o}
            !== {1'b1, 32'hB000_0000, 1'b0}) begin
            errors++;
            $display("FAIL t1_ack: iack %b idat %h dack %b want 1 b0000000 0",
                     iwb_ack_o, iwb_dat_o, dwb_ack_o);
        end
        tick();
        iwb_stb_i = 1'b0;
        mwb_ack_i = 1'b0;
        #1;
        checks++;
        if ({iwb_ack_o, mwb_stb_o} !== 2'b00) begin
            errors++;
            $display("FAIL t1_done: ack %b stb %b want 0 0",
                     iwb_ack_o, mwb_stb_o);
        end
        m_last_d = 1'b0;
    endtask

    task automatic test_tie;
        tick();
        iwb_stb_i = 1'b1;
        iwb_adr_i = 30'h20;
        dwb_stb_i = 1'b1;
        dwb_wre_i = 1'b1;
        dwb_sel_i = 4'h3;
        dwb_adr_i = 30'h40;
        dwb_dat_i = 32'hDEAD_BEEF;
        tick();
        mwb_ack_i = 1'b1;
        #1;
        checks++;
        if ({dwb_ack_o, iwb_ack_o, mwb_we_o, mwb_sel_o, mwb_adr_o, mwb_dat_o}
            !== {1'b1, 1'b0, 1'b1, 4'h3, 30'h40, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL t2_dwb: dack %b iack %b we %b sel %h adr %h dat %h",
                     dwb_ack_o, iwb_ack_o, mwb_we_o, mwb_sel_o,
                     mwb_adr_o, mwb_dat_o);
        end
        tick();
        dwb_stb_i = 1'b0;
        mwb_ack_i = 1'b0;
        #1;
        checks++;
        if ({mwb_stb_o, dwb_ack_o, iwb_ack_o} !== 3'b000) begin
            errors++;
            $display("FAIL t2_gap: stb %b dack %b iack %b want 0",
                     mwb_stb_o, dwb_ack_o, iwb_ack_o);
        end
        tick();
        #1;
        checks++;
        if ({mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o, mwb_dat_o}
            !== {1'b1, 1'b0, 4'hF, 30'h20, 32'h0}) begin
            errors++;
            $display("FAIL t2_iwb: stb %b we %b sel %h adr %h dat %h",
                     mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o, mwb_dat_o);
        end
        tick();
        mwb_ack_i = 1'b1;
        mwb_dat_i = 32'h0BAD_F00D;
        #1;
        checks++;
        if ({iwb_ack_o, iwb_dat_o, dwb_ack_o, dwb_dat_o}
            !== {1'b1, 32'h0BAD_F00D, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL t2_iack: iack %b idat %h dack %b ddat %h",
                     iwb_ack_o, iwb_dat_o, dwb_ack_o, dwb_dat_o);
        end
        tick();
        iwb_stb_i = 1'b0;
        mwb_ack_i = 1'b0;
        m_last_d = 1'b0;
    endtask

    task automatic test_rr_order;
        bit exp_d;
        do_reset();
        iwb_stb_i = 1'b1;
        iwb_adr_i = 30'h111;
        dwb_stb_i = 1'b1;
        dwb_adr_i = 30'h222;
        for (int n = 0; n < 4; n++) begin
            exp_d = !RR || !m_last_d;
            #1;
            checks++;
            if (mwb_stb_o !== 1'b0) begin
                errors++;
                $display("FAIL t3_gap%0d: stb %b want 0", n, mwb_stb_o);
            end
            tick();
            mwb_ack_i = 1'b1;
            #1;
            checks++;
            if ({mwb_adr_o, dwb_ack_o, iwb_ack_o}
                !== {(exp_d ? 30'h222 : 30'h111), exp_d, !exp_d}) begin
                errors++;
                $display("FAIL t3_order%0d: adr %h dack %b iack %b want d=%b",
                         n, mwb_adr_o, dwb_ack_o, iwb_ack_o, exp_d);
            end
            m_last_d = exp_d;
            tick();
            mwb_ack_i = 1'b0;
        end
        iwb_stb_i = 1'b0;
        dwb_stb_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        dwb_stb_i = 1'b1;
        dwb_adr_i = 30'h300;
        mwb_dat_i = 32'hFFFF_FFFF;
        for (int c = 1; c <= LIM; c++) begin
            tick();
            #1;
            checks++;
            if ({dwb_ack_o, mwb_stb_o, tmo_o, dwb_dat_o}
                !== {(c == LIM), (c != LIM), 1'b0,
                     ((c == LIM) ? 32'h0 : 32'hFFFF_FFFF)}) begin
                errors++;
                $display("FAIL t4_cyc%0d: ack %b stb %b tmo %b dat %h",
                         c, dwb_ack_o, mwb_stb_o, tmo_o, dwb_dat_o);
            end
        end
        tick();
        dwb_stb_i = 1'b0;
        #1;
        checks++;
        if ({tmo_o, dwb_ack_o} !== 2'b10) begin
            errors++;
            $display("FAIL t4_flag: tmo %b ack %b want 1 0", tmo_o, dwb_ack_o);
        end
        repeat (4) tick();
        #1;
        checks++;
        if (tmo_o !== 1'b1) begin
            errors++;
            $display("FAIL t4_sticky: tmo %b want 1", tmo_o);
        end
        m_tmo = 1'b1;
    endtask

    task automatic test_ack_at_limit;
        do_reset();
        dwb_stb_i = 1'b1;
        dwb_adr_i = 30'h304;
        mwb_dat_i = 32'h1234_5678;
        for (int c = 1; c <= LIM; c++) begin
            tick();
            mwb_ack_i = (c == LIM);
            #1;
            checks++;
            if ({dwb_ack_o, mwb_stb_o} !== {(c == LIM), 1'b1}) begin
                errors++;
                $display("FAIL t5_cyc%0d: ack %b stb %b", c, dwb_ack_o, mwb_stb_o);
            end
        end
        checks++;
        if (dwb_dat_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL t5_dat: got %h want 12345678", dwb_dat_o);
        end
        tick();
        dwb_stb_i = 1'b0;
        mwb_ack_i = 1'b0;
        #1;
        checks++;
        if (tmo_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_tmo: got %b want 0", tmo_o);
        end
        m_last_d = 1'b1;
    endtask

    task automatic test_abort_reset;
        tick();
        dwb_stb_i = 1'b1;
        dwb_wre_i = 1'b1;
        dwb_sel_i = 4'hF;
        dwb_adr_i = 30'h50;
        dwb_dat_i = 32'hCAFE_0001;
        mwb_dat_i = 32'h5555_AAAA;
        tick();
        #1;
        checks++;
        if (mwb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL t6_grant: stb %b want 1", mwb_stb_o);
        end
        tick();
        sys_rst_i = 1'b1;
        mwb_ack_i = 1'b1;
        #1;
        checks++;
        if (w_outs !== '0) begin
            errors++;
            $display("FAIL t6_in_reset: got %h want 0", w_outs);
        end
        tick();
        sys_rst_i = 1'b0;
        mwb_ack_i = 1'b0;
        m_last_d = 1'b0;
        m_tmo = 1'b0;
        #1;
        checks++;
        if (w_outs !== '0) begin
            errors++;
            $display("FAIL t6_after_reset: got %h want 0", w_outs);
        end
        tick();
        #1;
        checks++;
        if (mwb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL t6_regrant: stb %b want 1", mwb_stb_o);
        end
        repeat (4) tick();
        tick();
        dwb_stb_i = 1'b0;
        mwb_ack_i = 1'b1;
        #1;
        checks++;
        if ({dwb_ack_o, mwb_stb_o} !== 2'b00) begin
            errors++;
            $display("FAIL t6_abort: ack %b stb %b want 0 0", dwb_ack_o, mwb_stb_o);
        end
        tick();
        mwb_ack_i = 1'b0;
        #1;
        checks++;
        if (w_outs !== '0) begin
            errors++;
            $display("FAIL t6_abort_idle: got %h want 0", w_outs);
        end
        dwb_stb_i = 1'b1;
        for (int c = 1; c <= LIM; c++) begin
            tick();
            #1;
            checks++;
            if (dwb_ack_o !== (c == LIM)) begin
                errors++;
                $display("FAIL t6_wdog_clr%0d: ack %b want %b",
                         c, dwb_ack_o, (c == LIM));
            end
        end
        tick();
        dwb_stb_i = 1'b0;
        m_tmo = 1'b1;
    endtask

    task automatic test_random;
        int  mode;
        int  n;
        int  dly;
        int  k;
        bit  md;
        bit  to;
        bit  exp_stb;
        bit  ord [2];
        logic [31:0] got_dat;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            iwb_adr_i = 30'($urandom);
            dwb_adr_i = 30'($urandom);
            dwb_dat_i = $urandom;
            dwb_sel_i = 4'($urandom);
            dwb_wre_i = 1'($urandom);
            mode = int'($urandom_range(0, 2));
            iwb_stb_i = (mode != 1);
            dwb_stb_i = (mode != 0);
            #1;
            checks++;
            if (mwb_stb_o !== 1'b0) begin
                errors++;
                $display("FAIL rnd_idle%0d: stb %b want 0", it, mwb_stb_o);
            end
            if (mode == 2) begin
                ord[0] = !RR || !m_last_d;
                ord[1] = !ord[0];
                n = 2;
            end else begin
                ord[0] = (mode == 1);
                n = 1;
            end
            for (int t = 0; t < n; t++) begin
                md  = ord[t];
                dly = int'($urandom_range(0, LIM + 1));
                to  = (dly + 1) > LIM;
                k   = to ? LIM : dly + 1;
                for (int c = 1; c <= k; c++) begin
                    tick();
                    mwb_ack_i = (c == dly + 1);
                    mwb_dat_i = $urandom;
                    #1;
                    exp_stb = !(to && c == LIM);
                    checks++;
                    if (mwb_stb_o !== exp_stb) begin
                        errors++;
                        $display("FAIL rnd_stb%0d.%0d: got %b want %b",
                                 it, c, mwb_stb_o, exp_stb);
                    end
                    if (exp_stb) begin
                        checks++;
                        if ({mwb_adr_o, mwb_we_o, mwb_sel_o}
                            !== {(md ? dwb_adr_i : iwb_adr_i),
                                 (md & dwb_wre_i),
                                 (md ? dwb_sel_i : 4'hF)}) begin
                            errors++;
                            $display("FAIL rnd_bus%0d.%0d: adr %h we %b sel %h d=%b",
                                     it, c, mwb_adr_o, mwb_we_o, mwb_sel_o, md);
                        end
                    end
                    checks++;
                    if ({dwb_ack_o, iwb_ack_o}
                        !== ((c == k) ? {md, !md} : 2'b00)) begin
                        errors++;
                        $display("FAIL rnd_ack%0d.%0d: dack %b iack %b d=%b last=%b",
                                 it, c, dwb_ack_o, iwb_ack_o, md, (c == k));
                    end
                    if (c == k) begin
                        got_dat = md ? dwb_dat_o : iwb_dat_o;
                        checks++;
                        if (got_dat !== (to ? 32'h0 : mwb_dat_i)) begin
                            errors++;
                            $display("FAIL rnd_dat%0d: got %h want %h",
                                     it, got_dat, (to ? 32'h0 : mwb_dat_i));
                        end
                    end
                end
                tick();
                mwb_ack_i = 1'b0;
                if (md) dwb_stb_i = 1'b0;
                else    iwb_stb_i = 1'b0;
                if (to) m_tmo = 1'b1;
                else    m_last_d = md;
                #1;
                checks++;
                if ({mwb_stb_o, tmo_o} !== {1'b0, m_tmo}) begin
                    errors++;
                    $display("FAIL rnd_gap%0d: stb %b tmo %b want 0 %b",
                             it, mwb_stb_o, tmo_o, m_tmo);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        sys_rst_i = 1'b1;
        test_reset();
        test_iwb_single();
        test_tie();
        test_rr_order();
        test_timeout();
        test_ack_at_limit();
        test_abort_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
